// File: rtl/time_set_editor_pkg.sv
// Shared state encoding, field codes, limits and the 17-bit HH:MM:SS packing
// used by the time-set editor and its button front end.
package time_set_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_EDIT_HR  = 3'd1,
      ST_EDIT_MIN = 3'd2,
      ST_EDIT_SEC = 3'd3,
      ST_COMMIT   = 3'd4
   } state_t;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HR   = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   localparam logic [4:0] HR_MAX = 5'd23;
   localparam logic [5:0] MS_MAX = 6'd59;

   localparam int TIME_W  = 17;
   localparam int HR_MSB  = 16;
   localparam int HR_LSB  = 12;
   localparam int MIN_MSB = 11;
   localparam int MIN_LSB = 6;
   localparam int SEC_MSB = 5;
   localparam int SEC_LSB = 0;

   // Out-of-range values (possible from a corrupt live time) wrap to a legal value.
   function automatic logic [4:0] hr_adjust(input logic [4:0] v, input logic up);
      if (up) begin
         return (v >= HR_MAX) ? 5'd0 : v + 5'd1;
      end else begin
         return ((v == 5'd0) || (v > HR_MAX)) ? HR_MAX : v - 5'd1;
      end
   endfunction

   function automatic logic [5:0] ms_adjust(input logic [5:0] v, input logic up);
      if (up) begin
         return (v >= MS_MAX) ? 6'd0 : v + 6'd1;
      end else begin
         return ((v == 6'd0) || (v > MS_MAX)) ? MS_MAX : v - 6'd1;
      end
   endfunction

   function automatic logic [TIME_W-1:0] pack_time(input logic [4:0] h, input logic [5:0] m,
                                                   input logic [5:0] s);
      return {h, m, s};
   endfunction

endpackage

// File: rtl/time_set_editor_btn_edge_repeat.sv
// Button front end: one sync flop, rising-edge detect and optional hold-to-repeat,
// producing a registered single-cycle step. REPEAT_DELAY of 0 disables repeat.
module btn_edge_repeat #(
   parameter int REPEAT_DELAY = 0,
   parameter int REPEAT_RATE  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic clear,
   output logic step,
   output logic held
);

   localparam bit          REP_EN    = (REPEAT_DELAY > 0);
   // The counter starts one edge after the sync flop goes high and the step is
   // registered, so the first repeat threshold sits two below the delay.
   localparam logic [31:0] FIRST_LIM = (REPEAT_DELAY > 1) ? 32'(REPEAT_DELAY - 2) : 32'd0;
   localparam logic [31:0] RATE_LIM  = (REPEAT_RATE > 1) ? 32'(REPEAT_RATE - 1) : 32'd0;

   logic        sync_r;
   logic        prev_r;
   logic        step_r;
   logic        rep_phase_r;
   logic [31:0] cnt_r;
   logic        edge_s;
   logic        rep_hit_s;
   logic [31:0] lim_s;

   // Edge detect and repeat threshold compare.
   always_comb begin
      edge_s    = sync_r & ~prev_r;
      lim_s     = rep_phase_r ? RATE_LIM : FIRST_LIM;
      rep_hit_s = 1'b0;
      if (REP_EN && sync_r && !clear) begin
         rep_hit_s = (cnt_r == lim_s);
      end else begin
         rep_hit_s = 1'b0;
      end
   end

   // Sync flop, edge history, hold counter and registered step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r      <= 1'b0;
         prev_r      <= 1'b0;
         step_r      <= 1'b0;
         rep_phase_r <= 1'b0;
         cnt_r       <= 32'd0;
      end else begin
         sync_r <= btn;
         prev_r <= sync_r;
         step_r <= edge_s | rep_hit_s;
         if (!sync_r || clear || !REP_EN) begin
            cnt_r       <= 32'd0;
            rep_phase_r <= 1'b0;
         end else if (rep_hit_s) begin
            cnt_r       <= 32'd0;
            rep_phase_r <= 1'b1;
         end else begin
            cnt_r <= cnt_r + 32'd1;
         end
      end
   end

   assign step = step_r;
   assign held = sync_r;

endmodule

// File: rtl/time_set_editor.sv
// Cursor-driven HH:MM:SS editor: captures the live time, edits one field at a
// time with wrap and auto-repeat, blinks the selected field and commits with a load strobe.
module time_set_editor
   import time_set_pkg::*;
#(
   parameter int REPEAT_DELAY = 50_000_000,
   parameter int REPEAT_RATE  = 10_000_000,
   parameter int BLINK_HALF   = 25_000_000
) (
   input  logic              clk_100Mhz,
   input  logic              reset_in,
   input  logic              edit_en,
   input  logic              btn_next,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic [TIME_W-1:0] time_in,
   output logic [TIME_W-1:0] time_out,
   output logic              load,
   output logic [1:0]        field,
   output logic [2:0]        blank_mask,
   output logic              editing
);

   localparam logic [31:0] BLINK_LIM = (BLINK_HALF > 1) ? 32'(BLINK_HALF - 1) : 32'd0;

   state_t      state_r;
   state_t      state_n;
   logic [4:0]  hr_r;
   logic [4:0]  hr_n;
   logic [5:0]  min_r;
   logic [5:0]  min_n;
   logic [5:0]  sec_r;
   logic [5:0]  sec_n;
   logic [31:0] blink_cnt_r;
   logic [31:0] blink_cnt_n;
   logic        phase_r;
   logic        phase_n;
   logic [1:0]  field_n;
   logic [2:0]  mask_n;
   logic        editing_n;

   logic        next_step_s;
   logic        up_step_s;
   logic        down_step_s;
   logic        up_held_s;
   logic        down_held_s;
   logic        next_held_unused_s;
   logic        both_s;
   logic        inc_s;
   logic        dec_s;
   logic        adj_s;
   logic        clear_s;

   btn_edge_repeat #(.REPEAT_DELAY(0), .REPEAT_RATE(1)) u_next (
      .clk   (clk_100Mhz),
      .rst_n (reset_in),
      .btn   (btn_next),
      .clear (1'b0),
      .step  (next_step_s),
      .held  (next_held_unused_s)
   );

   btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
      .clk   (clk_100Mhz),
      .rst_n (reset_in),
      .btn   (btn_up),
      .clear (clear_s),
      .step  (up_step_s),
      .held  (up_held_s)
   );

   btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
      .clk   (clk_100Mhz),
      .rst_n (reset_in),
      .btn   (btn_down),
      .clear (clear_s),
      .step  (down_step_s),
      .held  (down_held_s)
   );

   // Next-state, working-value, blink and output decode.
   always_comb begin
      state_n     = state_r;
      hr_n        = hr_r;
      min_n       = min_r;
      sec_n       = sec_r;
      blink_cnt_n = blink_cnt_r;
      phase_n     = phase_r;
      adj_s       = 1'b0;
      // Both buttons down, or both edges at once, cancel each other.
      both_s = (up_held_s & down_held_s) | (up_step_s & down_step_s);
      inc_s  = up_step_s & ~both_s;
      dec_s  = down_step_s & ~both_s;

      case (state_r)
         ST_IDLE: begin
            if (next_step_s && edit_en) begin
               state_n = ST_EDIT_HR;
               hr_n    = time_in[HR_MSB:HR_LSB];
               min_n   = time_in[MIN_MSB:MIN_LSB];
               sec_n   = time_in[SEC_MSB:SEC_LSB];
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_EDIT_HR: begin
            if (!edit_en) begin
               state_n = ST_IDLE;
            end else if (next_step_s) begin
               state_n = ST_EDIT_MIN;
            end else if (inc_s || dec_s) begin
               hr_n  = hr_adjust(hr_r, inc_s);
               adj_s = 1'b1;
            end else begin
               state_n = ST_EDIT_HR;
            end
         end
         ST_EDIT_MIN: begin
            if (!edit_en) begin
               state_n = ST_IDLE;
            end else if (next_step_s) begin
               state_n = ST_EDIT_SEC;
            end else if (inc_s || dec_s) begin
               min_n = ms_adjust(min_r, inc_s);
               adj_s = 1'b1;
            end else begin
               state_n = ST_EDIT_MIN;
            end
         end
         ST_EDIT_SEC: begin
            if (!edit_en) begin
               state_n = ST_IDLE;
            end else if (next_step_s) begin
               state_n = ST_COMMIT;
            end else if (inc_s || dec_s) begin
               sec_n = ms_adjust(sec_r, inc_s);
               adj_s = 1'b1;
            end else begin
               state_n = ST_EDIT_SEC;
            end
         end
         ST_COMMIT: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      clear_s = (state_n != state_r) | both_s;

      // A fresh value or cursor position is always shown visible first.
      if (adj_s || (state_n != state_r)) begin
         blink_cnt_n = 32'd0;
         phase_n     = 1'b0;
      end else if (blink_cnt_r == BLINK_LIM) begin
         blink_cnt_n = 32'd0;
         phase_n     = ~phase_r;
      end else begin
         blink_cnt_n = blink_cnt_r + 32'd1;
         phase_n     = phase_r;
      end

      case (state_n)
         ST_EDIT_HR: begin
            field_n   = FIELD_HR;
            mask_n    = {phase_n, 2'b00};
            editing_n = 1'b1;
         end
         ST_EDIT_MIN: begin
            field_n   = FIELD_MIN;
            mask_n    = {1'b0, phase_n, 1'b0};
            editing_n = 1'b1;
         end
         ST_EDIT_SEC: begin
            field_n   = FIELD_SEC;
            mask_n    = {2'b00, phase_n};
            editing_n = 1'b1;
         end
         default: begin
            field_n   = FIELD_NONE;
            mask_n    = 3'b000;
            editing_n = 1'b0;
         end
      endcase
   end

   // State, working registers and registered outputs.
   always_ff @(posedge clk_100Mhz or negedge reset_in) begin
      if (!reset_in) begin
         state_r     <= ST_IDLE;
         hr_r        <= 5'd0;
         min_r       <= 6'd0;
         sec_r       <= 6'd0;
         blink_cnt_r <= 32'd0;
         phase_r     <= 1'b0;
         time_out    <= {TIME_W{1'b0}};
         load        <= 1'b0;
         field       <= FIELD_NONE;
         blank_mask  <= 3'b000;
         editing     <= 1'b0;
      end else begin
         state_r     <= state_n;
         hr_r        <= hr_n;
         min_r       <= min_n;
         sec_r       <= sec_n;
         blink_cnt_r <= blink_cnt_n;
         phase_r     <= phase_n;
         load        <= (state_n == ST_COMMIT);
         if (state_n == ST_COMMIT) begin
            time_out <= pack_time(hr_r, min_r, sec_r);
         end else begin
            time_out <= time_out;
         end
         field      <= field_n;
         blank_mask <= mask_n;
         editing    <= editing_n;
      end
   end

endmodule

// File: tb/tb_time_set_editor.sv
// Directed self-checking bench for time_set_editor with short repeat/blink timing.
module tb_time_set_editor;

   logic        clk_100Mhz = 1'b0;
   logic        reset_in   = 1'b0;
   logic        edit_en    = 1'b0;
   logic        btn_next   = 1'b0;
   logic        btn_up     = 1'b0;
   logic        btn_down   = 1'b0;
   logic [16:0] time_in    = 17'd0;
   logic [16:0] time_out;
   logic        load;
   logic [1:0]  field;
   logic [2:0]  blank_mask;
   logic        editing;

   int checks = 0;
   int errors = 0;

   time_set_editor #(.REPEAT_DELAY(20), .REPEAT_RATE(5), .BLINK_HALF(8)) dut (
      .clk_100Mhz (clk_100Mhz),
      .reset_in   (reset_in),
      .edit_en    (edit_en),
      .btn_next   (btn_next),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .time_in    (time_in),
      .time_out   (time_out),
      .load       (load),
      .field      (field),
      .blank_mask (blank_mask),
      .editing    (editing)
   );

   always #5 clk_100Mhz = ~clk_100Mhz;

   function automatic logic [16:0] hms(input int h, input int m, input int s);
      return {5'(h), 6'(m), 6'(s)};
   endfunction

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_100Mhz);
         #1;
      end
   endtask

   // One-cycle press, then wait until the result is visible (edge k+2).
   task automatic press(input logic n, input logic u, input logic d);
      btn_next = n;
      btn_up   = u;
      btn_down = d;
      tick(1);
      btn_next = 1'b0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      tick(2);
   endtask

   initial begin
      #12;
      chk("rst_time_out", time_out, 17'd0);
      chk("rst_load", 17'(load), 17'd0);
      chk("rst_field", 17'(field), 17'd0);
      chk("rst_mask", 17'(blank_mask), 17'd0);
      chk("rst_editing", 17'(editing), 17'd0);
      reset_in = 1'b1;
      tick(2);
      chk("idle_editing", 17'(editing), 17'd0);

      // Enter and commit unchanged value
      time_in = hms(12, 34, 56);
      edit_en = 1'b1;
      press(1'b1, 1'b0, 1'b0);
      chk("enter_editing", 17'(editing), 17'd1);
      chk("enter_field", 17'(field), 17'd1);
      chk("enter_mask", 17'(blank_mask), 17'd0);
      press(1'b1, 1'b0, 1'b0);
      chk("cursor_min", 17'(field), 17'd2);
      press(1'b1, 1'b0, 1'b0);
      chk("cursor_sec", 17'(field), 17'd3);
      press(1'b1, 1'b0, 1'b0);
      chk("commit1_load", 17'(load), 17'd1);
      chk("commit1_value", time_out, hms(12, 34, 56));
      chk("commit1_editing", 17'(editing), 17'd0);
      tick(1);
      chk("commit1_load_low", 17'(load), 17'd0);
      chk("commit1_field", 17'(field), 17'd0);
      chk("commit1_hold", time_out, hms(12, 34, 56));

      // Wrap-around hr up and min down
      time_in = hms(23, 0, 56);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      chk("wrap_field_min", 17'(field), 17'd2);
      press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      chk("commit2_load", 17'(load), 17'd1);
      chk("commit2_value", time_out, hms(0, 59, 56));
      tick(1);
      chk("commit2_load_low", 17'(load), 17'd0);
      tick(5);
      chk("commit2_hold", time_out, hms(0, 59, 56));

      // Up in IDLE and next with edit_en low are ignored
      press(1'b0, 1'b1, 1'b0);
      chk("idle_up_field", 17'(field), 17'd0);
      edit_en = 1'b0;
      press(1'b1, 1'b0, 1'b0);
      chk("no_enable_editing", 17'(editing), 17'd0);
      edit_en = 1'b1;

      // Abort from EDIT_MIN
      time_in = hms(1, 2, 3);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      chk("abort_field_min", 17'(field), 17'd2);
      edit_en = 1'b0;
      tick(1);
      chk("abort_editing", 17'(editing), 17'd0);
      chk("abort_field", 17'(field), 17'd0);
      for (int i = 0; i < 4; i++) begin
         chk("abort_load", 17'(load), 17'd0);
         tick(1);
      end
      chk("abort_time_out", time_out, hms(0, 59, 56));
      edit_en = 1'b1;

      // next+up together, blink, repeat, commit
      time_in = hms(5, 10, 58);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b1, 1'b0);
      chk("next_up_field", 17'(field), 17'd2);
      chk("blink_t0", 17'(blank_mask), 17'd0);
      tick(7);
      chk("blink_t7", 17'(blank_mask), 17'd0);
      tick(1);
      chk("blink_t8", 17'(blank_mask), 17'b010);
      tick(7);
      chk("blink_t15", 17'(blank_mask), 17'b010);
      tick(1);
      chk("blink_t16", 17'(blank_mask), 17'd0);
      tick(7);
      btn_up = 1'b1;
      tick(1);
      btn_up = 1'b0;
      tick(1);
      chk("blink_before_step", 17'(blank_mask), 17'b010);
      tick(1);
      chk("blink_forced", 17'(blank_mask), 17'd0);
      press(1'b1, 1'b0, 1'b0);
      chk("repeat_field_sec", 17'(field), 17'd3);
      btn_up = 1'b1;
      for (int i = 1; i <= 36; i++) begin
         tick(1);
         if (i == 11) chk("repeat_mask_k10", 17'(blank_mask), 17'b001);
         if (i == 20) chk("repeat_mask_k19", 17'(blank_mask), 17'd0);
         if (i == 30) chk("repeat_mask_k29", 17'(blank_mask), 17'd0);
      end
      btn_up = 1'b0;
      tick(3);
      press(1'b1, 1'b0, 1'b0);
      chk("commit3_load", 17'(load), 17'd1);
      chk("commit3_value", time_out, hms(5, 11, 3));
      tick(1);

      // Both up+down ignored, hr 0-1 and sec 0-1 wrap
      time_in = hms(0, 0, 0);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b1);
      press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      chk("commit4_load", 17'(load), 17'd1);
      chk("commit4_value", time_out, hms(23, 0, 59));
      tick(1);

      // Async reset mid-edit
      time_in = hms(7, 7, 7);
      press(1'b1, 1'b0, 1'b0);
      chk("pre_reset_editing", 17'(editing), 17'd1);
      #3;
      reset_in = 1'b0;
      #1;
      chk("async_time_out", time_out, 17'd0);
      chk("async_editing", 17'(editing), 17'd0);
      chk("async_field", 17'(field), 17'd0);
      chk("async_mask", 17'(blank_mask), 17'd0);
      chk("async_load", 17'(load), 17'd0);
      #2;
      reset_in = 1'b1;
      tick(3);
      chk("post_reset_editing", 17'(editing), 17'd0);
      chk("post_reset_load", 17'(load), 17'd0);
      chk("post_reset_time_out", time_out, 17'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
